// File: rtl/rggen_axi4lite_front_if.sv
// rggen_axi4lite_front_if: AXI4-Lite slave channels plus the common bus request/response
// slave  : front-end view (AXI requests and bus completion in, AXI responses and bus request out)
// master : surrounding system view (interconnect plus register-block adapter)
interface rggen_axi4lite_front_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                     awvalid;
    logic                     awready;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [BUS_WIDTH-1:0]     rdata;
    logic [1:0]               rresp;
    logic                     bus_valid;
    logic [1:0]               bus_access;
    logic [ADDRESS_WIDTH-1:0] bus_address;
    logic [BUS_WIDTH-1:0]     bus_write_data;
    logic [BUS_WIDTH/8-1:0]   bus_strobe;
    logic                     bus_ready;
    logic [1:0]               bus_status;
    logic [BUS_WIDTH-1:0]     bus_read_data;
    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready, bus_ready, bus_status, bus_read_data,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
               bus_valid, bus_access, bus_address, bus_write_data, bus_strobe
    );
    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready, bus_ready, bus_status, bus_read_data,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
               bus_valid, bus_access, bus_address, bus_write_data, bus_strobe
    );
endinterface

// File: rtl/rggen_axi4lite_front.sv
// rggen_axi4lite_front: AXI4-Lite slave front-end issuing one request at a time to the common bus
// i_clk   : clock
// i_rst_n : asynchronous active-low reset
// axi_if  : AW/W/AR buffered with one entry each, B/R responses, and the common bus request/completion
module rggen_axi4lite_front #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter bit WRITE_FIRST   = 1'b1
)(
    input logic                   i_clk,
    input logic                   i_rst_n,
    rggen_axi4lite_front_if.slave axi_if
);
    localparam int                       STRB_WIDTH   = BUS_WIDTH / 8;
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK    = ~ADDRESS_WIDTH'(STRB_WIDTH - 1);
    localparam logic [1:0]               ACCESS_WRITE = 2'b01;
    localparam logic [1:0]               ACCESS_READ  = 2'b10;
    typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
    state_e                   state;
    state_e                   state_next;
    logic                     ready_en;
    logic                     aw_full;
    logic                     w_full;
    logic                     ar_full;
    logic [ADDRESS_WIDTH-1:0] aw_addr;
    logic [ADDRESS_WIDTH-1:0] ar_addr;
    logic [BUS_WIDTH-1:0]     w_data;
    logic [STRB_WIDTH-1:0]    w_strb;
    logic                     last_write;
    logic [1:0]               access;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [BUS_WIDTH-1:0]     write_data;
    logic [STRB_WIDTH-1:0]    strobe;
    logic [1:0]               status;
    logic [BUS_WIDTH-1:0]     read_data;
    logic                     grant_write;
    logic                     grant_read;
    logic                     bus_done;
    logic                     resp_done;
    logic                     unused;
    assign unused      = ^{axi_if.awprot, axi_if.arprot};
    // both pending: take the kind not granted last; a single pending kind always wins
    assign grant_write = state == IDLE && aw_full && w_full && (!ar_full || !last_write);
    assign grant_read  = state == IDLE && ar_full && !grant_write;
    assign bus_done    = state == BUS && axi_if.bus_ready;
    assign resp_done   = state == RESP && (access == ACCESS_WRITE ? axi_if.bready : axi_if.rready);
    // ready_en keeps every ready low while in reset and lifts them one cycle after release
    assign axi_if.awready        = ready_en && !aw_full;
    assign axi_if.wready         = ready_en && !w_full;
    assign axi_if.arready        = ready_en && !ar_full;
    assign axi_if.bus_valid      = state == BUS;
    assign axi_if.bus_access     = access;
    assign axi_if.bus_address    = address;
    assign axi_if.bus_write_data = write_data;
    assign axi_if.bus_strobe     = strobe;
    assign axi_if.bvalid         = state == RESP && access == ACCESS_WRITE;
    assign axi_if.rvalid         = state == RESP && access == ACCESS_READ;
    assign axi_if.bresp          = status;
    assign axi_if.rresp          = status;
    assign axi_if.rdata          = read_data;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_en <= 1'b0;
            aw_full  <= 1'b0;
            w_full   <= 1'b0;
            ar_full  <= 1'b0;
            aw_addr  <= '0;
            ar_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (axi_if.awvalid && axi_if.awready) begin
                aw_full <= 1'b1;
                aw_addr <= axi_if.awaddr;
            end else if (bus_done && access == ACCESS_WRITE) begin
                aw_full <= 1'b0;
            end
            if (axi_if.wvalid && axi_if.wready) begin
                w_full <= 1'b1;
                w_data <= axi_if.wdata;
                w_strb <= axi_if.wstrb;
            end else if (bus_done && access == ACCESS_WRITE) begin
                w_full <= 1'b0;
            end
            if (axi_if.arvalid && axi_if.arready) begin
                ar_full <= 1'b1;
                ar_addr <= axi_if.araddr;
            end else if (bus_done && access == ACCESS_READ) begin
                ar_full <= 1'b0;
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = (grant_write || grant_read) ? BUS : IDLE;
            BUS:     state_next = axi_if.bus_ready ? RESP : BUS;
            RESP:    state_next = resp_done ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_write <= !WRITE_FIRST;
            access     <= 2'b00;
            address    <= '0;
            write_data <= '0;
            strobe     <= '0;
            status     <= 2'b00;
            read_data  <= '0;
        end else begin
            if (grant_write) begin
                last_write <= 1'b1;
                access     <= ACCESS_WRITE;
                address    <= aw_addr & ADDR_MASK;
                write_data <= w_data;
                strobe     <= w_strb;
            end else if (grant_read) begin
                last_write <= 1'b0;
                access     <= ACCESS_READ;
                address    <= ar_addr & ADDR_MASK;
                write_data <= '0;
                strobe     <= '1;
            end
            if (bus_done) begin
                status <= axi_if.bus_status;
                if (access == ACCESS_READ) read_data <= axi_if.bus_read_data;
            end
        end
    end
endmodule
